// File: rtl/vga_mode_sequencer_if.sv
// Bundle between vga_mode_sequencer and its environment: request/response, timing pulses and Config write port.
// The sequencer is the slave; the requesters, the timing generator and Config together form the master side.
interface vga_mode_sequencer_if #(
    parameter int CONFIG_WIDTH = 4
);
    logic [1:0]              req;
    logic [1:0]              mode0;
    logic [1:0]              mode1;
    logic                    frame_start;
    logic                    load_config;
    logic                    valid;
    logic [CONFIG_WIDTH-1:0] addr;
    logic [CONFIG_WIDTH-1:0] data;
    logic                    blank;
    logic                    busy;
    logic [1:0]              ack;
    logic [1:0]              err;
    logic [1:0]              cur_mode;

    modport master (
        output req, mode0, mode1, frame_start, load_config,
        input  valid, addr, data, blank, busy, ack, err, cur_mode
    );

    modport slave (
        input  req, mode0, mode1, frame_start, load_config,
        output valid, addr, data, blank, busy, ack, err, cur_mode
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Round-robin VGA mode-change sequencer: blank at frame boundary, write Config, await load, settle, acknowledge.
// Optional macro VGA_MODE_SEQ_SKIP_SAME_EN: a request for the already-active mode is acknowledged without a sequence.
module vga_mode_sequencer #(
    parameter int                      CONFIG_WIDTH  = 4,
    parameter logic [CONFIG_WIDTH-1:0] CFG_ADDR      = CONFIG_WIDTH'(4'b1011),
    parameter int                      SETTLE_FRAMES = 2,
    parameter int                      LOAD_TIMEOUT  = 15
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vga_mode_sequencer_if.slave bus
);

    localparam logic [7:0] LOAD_TIMEOUT_C  = 8'(LOAD_TIMEOUT);
    localparam logic [3:0] SETTLE_FRAMES_C = 4'(SETTLE_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_WRITE,
        ST_WAIT_LOAD,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    gnt_q, gnt_d;
    logic [1:0]              mode_q, mode_d;
    logic [1:0]              cur_mode_q, cur_mode_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [3:0]              frame_cnt_q, frame_cnt_d;
    logic                    just_done_q, just_done_d;
    logic                    valid_q, valid_d;
    logic [CONFIG_WIDTH-1:0] addr_q, addr_d;
    logic [CONFIG_WIDTH-1:0] data_q, data_d;
    logic                    blank_q, blank_d;
    logic                    busy_q, busy_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0]              err_q, err_d;

    logic [1:0]              served_mask;
    logic [1:0]              req_eff;
    logic [1:0]              gnt_onehot_d;

    // The requester just served is hidden for the single IDLE cycle after DONE/ERR.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign served_mask[gi]  = just_done_q && (int'(gnt_q) == gi);
        assign gnt_onehot_d[gi] = (int'(gnt_d) == gi);
    end

    assign req_eff = bus.req & ~served_mask;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            mode_q      <= 2'b00;
            cur_mode_q  <= 2'b00;
            wait_cnt_q  <= 8'd0;
            frame_cnt_q <= 4'd0;
            just_done_q <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            mode_q      <= mode_d;
            cur_mode_q  <= cur_mode_d;
            wait_cnt_q  <= wait_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            just_done_q <= just_done_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        mode_d      = mode_q;
        wait_cnt_d  = wait_cnt_q;
        frame_cnt_d = frame_cnt_q;
        just_done_d = (state_q == ST_DONE) || (state_q == ST_ERR);

        unique case (state_q)
            ST_IDLE: begin
                if (req_eff != 2'b00) begin
                    gnt_d  = (req_eff == 2'b11) ? ptr_q : req_eff[1];
                    ptr_d  = ~gnt_d;
                    mode_d = gnt_d ? bus.mode1 : bus.mode0;
                    if (mode_d == 2'b11) begin
                        state_d = ST_ERR;
`ifdef VGA_MODE_SEQ_SKIP_SAME_EN
                    end else if (mode_d == cur_mode_q) begin
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (bus.frame_start) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wait_cnt_d  = 8'd0;
                frame_cnt_d = 4'd0;
                state_d     = bus.load_config ? ST_SETTLE : ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                if (bus.load_config) begin
                    frame_cnt_d = 4'd0;
                    state_d     = ST_SETTLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == LOAD_TIMEOUT_C) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.frame_start) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                    if (frame_cnt_d == SETTLE_FRAMES_C) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        valid_d    = (state_d == ST_WRITE);
        addr_d     = valid_d ? CFG_ADDR : '0;
        data_d     = valid_d ? CONFIG_WIDTH'(mode_d) : '0;
        blank_d    = (state_d == ST_BLANK) || (state_d == ST_WRITE) ||
                     (state_d == ST_WAIT_LOAD) || (state_d == ST_SETTLE);
        busy_d     = (state_d != ST_IDLE);
        ack_d      = (state_d == ST_DONE) ? gnt_onehot_d : 2'b00;
        err_d      = (state_d == ST_ERR) ? gnt_onehot_d : 2'b00;
        cur_mode_d = (state_d == ST_DONE) ? mode_d : cur_mode_q;
    end

    assign bus.valid    = valid_q;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.blank    = blank_q;
    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.cur_mode = cur_mode_q;

endmodule
